egress_tx_ctrl: RTL and testbench

Per-port egress transmit sequencer that drains the output post stage's frame-pointer FIFO and byte data FIFO and drives a byte-wide MAC transmit interface. It pops one frame-length entry, reads exactly that many bytes from the data FIFO, presents them as a contiguous `tx_en`/`txd` burst, and enforces a programmable inter-frame gap. It sits between the switch output post-processing stage and the per-port GMII/MAC transmitter, and supports frame-boundary pause.

---
 rtl/egress_tx_ctrl_if.sv | 26 ++
 rtl/egress_tx_ctrl.sv | 100 ++++++++++
 tb/tb_egress_tx_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/egress_tx_ctrl_if.sv
// egress_tx_ctrl_if: FIFO-side and MAC-side signals of the egress transmit sequencer.
//   master (controller): pops the pointer/data FIFOs, drives tx_en/txd, status and counters.
//   slave (environment): supplies FIFO flags/data and tx_pause, observes everything else.
interface egress_tx_ctrl_if;
    logic        ptr_fifo_empty;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout;
    logic        tx_pause;
    logic        tx_en;
    logic [7:0]  txd;
    logic        tx_busy;
    logic        frame_done;
    logic        len_err;
    logic [15:0] frame_cnt;
    logic [31:0] byte_cnt;
    modport master (
        input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_pause,
        output ptr_fifo_rd, data_fifo_rd, tx_en, txd, tx_busy, frame_done, len_err, frame_cnt, byte_cnt
    );
    modport slave (
        output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_pause,
        input  ptr_fifo_rd, data_fifo_rd, tx_en, txd, tx_busy, frame_done, len_err, frame_cnt, byte_cnt
    );
endinterface

// File: rtl/egress_tx_ctrl.sv
// egress_tx_ctrl: pops a frame length, streams that many bytes from the data FIFO to the MAC, then holds an inter-frame gap.
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : egress_tx_ctrl_if.master (pointer/data FIFO pops, tx_en/txd, tx_busy, frame_done, len_err, frame_cnt, byte_cnt)
module egress_tx_ctrl #(
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic              clk,
    input  logic              rstn,
    egress_tx_ctrl_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_PTR, S_LEN, S_DATA, S_TAIL, S_IFG} state_t;
    state_t      state_q, state_d;
    logic [11:0] rem_q, rem_d;
    logic [7:0]  ifg_q, ifg_d;
    logic        tail_q, tail_d;
    logic        len_err_d;
    logic        ptr_rd_q, data_rd_q, rd_d1_q, tx_en_q, busy_q, frame_done_q, len_err_q;
    logic [7:0]  txd_q;
    logic [15:0] frame_cnt_q;
    logic [31:0] byte_cnt_q;
    logic        last_byte;
    logic        unused_len_hi;
    assign unused_len_hi = ^bus.ptr_fifo_dout[15:12];
    // the byte in the pipeline's middle stage is the frame's last one once the FIFO read strobe has dropped
    assign last_byte = rd_d1_q & ~data_rd_q;
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        ifg_d     = ifg_q;
        tail_d    = tail_q;
        len_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = (!bus.ptr_fifo_empty && !bus.tx_pause) ? S_PTR : S_IDLE;
            S_PTR:  state_d = S_LEN;
            S_LEN: begin
                rem_d     = bus.ptr_fifo_dout[11:0];
                len_err_d = (bus.ptr_fifo_dout[11:0] == 12'd0);
                state_d   = len_err_d ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                rem_d   = rem_q - 12'd1;
                tail_d  = 1'b0;
                state_d = (rem_q == 12'd1) ? S_TAIL : S_DATA;
            end
            S_TAIL: begin
                tail_d  = 1'b1;
                ifg_d   = 8'(IFG_BYTES);
                state_d = tail_q ? S_IFG : S_TAIL;
            end
            S_IFG: begin
                ifg_d   = ifg_q - 8'd1;
                state_d = (ifg_q == 8'd1) ? S_IDLE : S_IFG;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // strobes are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            ifg_q        <= '0;
            tail_q       <= 1'b0;
            ptr_rd_q     <= 1'b0;
            data_rd_q    <= 1'b0;
            rd_d1_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            txd_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            frame_cnt_q  <= '0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            ifg_q        <= ifg_d;
            tail_q       <= tail_d;
            ptr_rd_q     <= (state_d == S_PTR);
            data_rd_q    <= (state_d == S_DATA);
            rd_d1_q      <= data_rd_q;
            tx_en_q      <= rd_d1_q;
            txd_q        <= rd_d1_q ? bus.data_fifo_dout : 8'h00;
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= last_byte;
            len_err_q    <= len_err_d;
            frame_cnt_q  <= frame_cnt_q + 16'(last_byte);
            byte_cnt_q   <= byte_cnt_q + 32'(rd_d1_q);
        end
    end
    assign bus.ptr_fifo_rd  = ptr_rd_q;
    assign bus.data_fifo_rd = data_rd_q;
    assign bus.tx_en        = tx_en_q;
    assign bus.txd          = txd_q;
    assign bus.tx_busy      = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.len_err      = len_err_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.byte_cnt     = byte_cnt_q;
endmodule

// File: tb/tb_egress_tx_ctrl.sv
// tb_egress_tx_ctrl: directed scenarios for egress_tx_ctrl against behavioural pointer/data FIFOs.
module tb_egress_tx_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    egress_tx_ctrl_if bus ();
    egress_tx_ctrl #(.IFG_BYTES(12)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    logic [15:0] pmem [0:63];
    logic [7:0]  dmem [0:1023];
    int pwp = 0, prp = 0, dwp = 0, drp = 0;
    int n_cmp = 0, n_bad = 0;
    logic [255:0] lp, ld, le, lf, ll, lb;
    logic [7:0]   lt [0:255];
    assign bus.ptr_fifo_empty = (pwp == prp);
    // FIFO model: dout valid the cycle after rd; shares rstn, so reset discards unread contents
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prp <= pwp;
            drp <= dwp;
            bus.ptr_fifo_dout  <= '0;
            bus.data_fifo_dout <= '0;
        end else begin
            if (bus.ptr_fifo_rd && pwp != prp) begin
                bus.ptr_fifo_dout <= pmem[prp % 64];
                prp <= prp + 1;
            end
            if (bus.data_fifo_rd) begin
                bus.data_fifo_dout <= dmem[drp % 1024];
                drp <= drp + 1;
            end
        end
    end
    task automatic push_frame(input int len, input int first);
        for (int i = 0; i < len; i++) begin
            dmem[dwp % 1024] = 8'(first + i);
            dwp++;
        end
        pmem[pwp % 64] = {4'hA, 12'(len)};
        pwp++;
    endtask
    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lp[start+i] = bus.ptr_fifo_rd;
            ld[start+i] = bus.data_fifo_rd;
            le[start+i] = bus.tx_en;
            lf[start+i] = bus.frame_done;
            ll[start+i] = bus.len_err;
            lb[start+i] = bus.tx_busy;
            lt[start+i] = bus.txd;
        end
    endtask
    function automatic int ones(input logic [255:0] v, input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(v[i]);
        return c;
    endfunction
    function automatic int txd_errs(input int at, input int n, input int first);
        int c = 0;
        for (int i = 0; i < n; i++) if (lt[at+i] !== 8'(first + i)) c++;
        return c;
    endfunction
    task automatic test_reset();
        bus.tx_pause = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({bus.ptr_fifo_rd, bus.data_fifo_rd, bus.tx_en, bus.txd, bus.tx_busy, bus.frame_done, bus.len_err} !== 13'h0) begin n_bad++; $display("FAIL reset_outputs: got %0h want 0", {bus.ptr_fifo_rd, bus.data_fifo_rd, bus.tx_en, bus.txd, bus.tx_busy, bus.frame_done, bus.len_err}); end
        n_cmp++; if ({bus.frame_cnt, bus.byte_cnt} !== 48'h0) begin n_bad++; $display("FAIL reset_counters: got %0h want 0", {bus.frame_cnt, bus.byte_cnt}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_single();
        push_frame(64, 0);
        capture(0, 84);
        n_cmp++; if (lp[0] !== 1'b1 || ones(lp, 0, 83) != 1) begin n_bad++; $display("FAIL single_ptr_rd: got first=%0b count=%0d want 1/1", lp[0], ones(lp, 0, 83)); end
        n_cmp++; if (ones(ld, 2, 65) != 64 || ones(ld, 0, 83) != 64) begin n_bad++; $display("FAIL single_data_rd: got %0d want 64", ones(ld, 0, 83)); end
        n_cmp++; if (ones(le, 4, 67) != 64 || ones(le, 0, 83) != 64) begin n_bad++; $display("FAIL single_tx_en: got %0d in window want 64", ones(le, 4, 67)); end
        n_cmp++; if (txd_errs(4, 64, 0) != 0) begin n_bad++; $display("FAIL single_txd: got %0d wrong bytes want 0", txd_errs(4, 64, 0)); end
        n_cmp++; if (lf[67] !== 1'b1 || ones(lf, 0, 83) != 1) begin n_bad++; $display("FAIL single_frame_done: got at67=%0b count=%0d want 1/1", lf[67], ones(lf, 0, 83)); end
        n_cmp++; if (lb[0] !== 1'b1 || lb[79] !== 1'b1 || lb[80] !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %0b%0b%0b want 110", lb[0], lb[79], lb[80]); end
        n_cmp++; if (bus.frame_cnt !== 16'd1 || bus.byte_cnt !== 32'd64) begin n_bad++; $display("FAIL single_counts: got %0d/%0d want 1/64", bus.frame_cnt, bus.byte_cnt); end
    endtask
    task automatic test_back_to_back();
        push_frame(60, 8'h40);
        push_frame(1, 8'hA5);
        capture(0, 100);
        n_cmp++; if (ones(le, 4, 63) != 60 || txd_errs(4, 60, 8'h40) != 0) begin n_bad++; $display("FAIL b2b_frame1: got %0d bytes %0d errs want 60/0", ones(le, 4, 63), txd_errs(4, 60, 8'h40)); end
        n_cmp++; if (ones(le, 64, 80) != 0 || le[81] !== 1'b1) begin n_bad++; $display("FAIL b2b_gap: got %0d busy gap cycles, next=%0b want 0/1", ones(le, 64, 80), le[81]); end
        n_cmp++; if (ones(le, 82, 99) != 0 || lt[81] !== 8'hA5 || lf[81] !== 1'b1) begin n_bad++; $display("FAIL b2b_frame2: got txd=%0h done=%0b extra=%0d want a5/1/0", lt[81], lf[81], ones(le, 82, 99)); end
        n_cmp++; if (bus.frame_cnt !== 16'd3 || bus.byte_cnt !== 32'd125) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want 3/125", bus.frame_cnt, bus.byte_cnt); end
    endtask
    task automatic test_zero_len();
        push_frame(0, 0);
        push_frame(10, 8'h10);
        capture(0, 60);
        n_cmp++; if (ll[2] !== 1'b1 || ones(ll, 0, 59) != 1) begin n_bad++; $display("FAIL zero_len_err: got at2=%0b count=%0d want 1/1", ll[2], ones(ll, 0, 59)); end
        n_cmp++; if (lp[0] !== 1'b1 || lp[3] !== 1'b1 || ones(lp, 0, 59) != 2) begin n_bad++; $display("FAIL zero_ptr_rd: got %0b%0b count=%0d want 11/2", lp[0], lp[3], ones(lp, 0, 59)); end
        n_cmp++; if (ones(ld, 0, 4) != 0 || ones(ld, 5, 14) != 10) begin n_bad++; $display("FAIL zero_data_rd: got early=%0d frame=%0d want 0/10", ones(ld, 0, 4), ones(ld, 5, 14)); end
        n_cmp++; if (ones(le, 7, 16) != 10 || txd_errs(7, 10, 8'h10) != 0) begin n_bad++; $display("FAIL zero_next_frame: got %0d bytes %0d errs want 10/0", ones(le, 7, 16), txd_errs(7, 10, 8'h10)); end
        n_cmp++; if (bus.frame_cnt !== 16'd4 || bus.byte_cnt !== 32'd135) begin n_bad++; $display("FAIL zero_counts: got %0d/%0d want 4/135", bus.frame_cnt, bus.byte_cnt); end
    endtask
    task automatic test_pause();
        bus.tx_pause = 1'b1;
        push_frame(8, 8'h80);
        push_frame(8, 8'h90);
        capture(0, 20);
        n_cmp++; if (ones(lp, 0, 19) != 0 || ones(lb, 0, 19) != 0) begin n_bad++; $display("FAIL pause_hold: got rd=%0d busy=%0d want 0/0", ones(lp, 0, 19), ones(lb, 0, 19)); end
        bus.tx_pause = 1'b0;
        capture(0, 6);
        bus.tx_pause = 1'b1;
        capture(6, 50);
        n_cmp++; if (lp[0] !== 1'b1 || ones(lp, 1, 55) != 0) begin n_bad++; $display("FAIL pause_f2_held: got first=%0b later=%0d want 1/0", lp[0], ones(lp, 1, 55)); end
        n_cmp++; if (ones(le, 4, 11) != 8 || ones(le, 0, 55) != 8 || txd_errs(4, 8, 8'h80) != 0) begin n_bad++; $display("FAIL pause_f1: got %0d bytes %0d errs want 8/0", ones(le, 0, 55), txd_errs(4, 8, 8'h80)); end
        bus.tx_pause = 1'b0;
        capture(0, 30);
        n_cmp++; if (lp[0] !== 1'b1 || ones(le, 4, 11) != 8 || txd_errs(4, 8, 8'h90) != 0) begin n_bad++; $display("FAIL pause_f2: got rd=%0b bytes=%0d errs=%0d want 1/8/0", lp[0], ones(le, 4, 11), txd_errs(4, 8, 8'h90)); end
        n_cmp++; if (bus.frame_cnt !== 16'd6 || bus.byte_cnt !== 32'd151) begin n_bad++; $display("FAIL pause_counts: got %0d/%0d want 6/151", bus.frame_cnt, bus.byte_cnt); end
    endtask
    task automatic test_reset_mid();
        push_frame(100, 0);
        capture(0, 24);
        n_cmp++; if (le[23] !== 1'b1 || lt[23] !== 8'd19) begin n_bad++; $display("FAIL rstmid_byte20: got en=%0b txd=%0h want 1/13", le[23], lt[23]); end
        rstn = 1'b0;
        #1;
        n_cmp++; if ({bus.ptr_fifo_rd, bus.data_fifo_rd, bus.tx_en, bus.txd, bus.tx_busy, bus.frame_done, bus.len_err} !== 13'h0) begin n_bad++; $display("FAIL rstmid_outputs: got %0h want 0", {bus.ptr_fifo_rd, bus.data_fifo_rd, bus.tx_en, bus.txd, bus.tx_busy, bus.frame_done, bus.len_err}); end
        n_cmp++; if ({bus.frame_cnt, bus.byte_cnt} !== 48'h0) begin n_bad++; $display("FAIL rstmid_counters: got %0h want 0", {bus.frame_cnt, bus.byte_cnt}); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        push_frame(5, 8'hC0);
        capture(0, 30);
        n_cmp++; if (lp[0] !== 1'b1 || ones(le, 4, 8) != 5 || ones(le, 0, 29) != 5 || txd_errs(4, 5, 8'hC0) != 0) begin n_bad++; $display("FAIL rstmid_fresh: got rd=%0b bytes=%0d errs=%0d want 1/5/0", lp[0], ones(le, 0, 29), txd_errs(4, 5, 8'hC0)); end
        n_cmp++; if (bus.frame_cnt !== 16'd1 || bus.byte_cnt !== 32'd5) begin n_bad++; $display("FAIL rstmid_counts: got %0d/%0d want 1/5", bus.frame_cnt, bus.byte_cnt); end
    endtask
    task automatic test_wrap();
        force dut.frame_cnt_q = 16'hFFFF;
        force dut.byte_cnt_q = 32'hFFFF_FFF0;
        @(negedge clk);
        release dut.frame_cnt_q;
        release dut.byte_cnt_q;
        @(negedge clk);
        n_cmp++; if (bus.frame_cnt !== 16'hFFFF || bus.byte_cnt !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL wrap_preload: got %0h/%0h want ffff/fffffff0", bus.frame_cnt, bus.byte_cnt); end
        push_frame(20, 8'h20);
        capture(0, 40);
        n_cmp++; if (bus.frame_cnt !== 16'h0000 || bus.byte_cnt !== 32'd4) begin n_bad++; $display("FAIL wrap_counts: got %0h/%0h want 0/4", bus.frame_cnt, bus.byte_cnt); end
        n_cmp++; if (ones(le, 4, 23) != 20 || lf[23] !== 1'b1 || ones(lf, 0, 39) != 1 || txd_errs(4, 20, 8'h20) != 0) begin n_bad++; $display("FAIL wrap_frame: got bytes=%0d done=%0d errs=%0d want 20/1/0", ones(le, 0, 39), ones(lf, 0, 39), txd_errs(4, 20, 8'h20)); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_pause();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
